// File: rtl/oled_request_scheduler_if.sv
// Request-side and display-side signal bundle for oled_request_scheduler.
// Handshake: o_START is a one-cycle strobe with the payload already stable;
// the engine acknowledges by dropping i_READY and completes by raising it again.
interface oled_request_scheduler_if #(
  parameter int N_REQ        = 4,
  parameter int G            = 64,
  parameter int N_COLOR_BITS = 8
);
  logic [N_REQ-1:0]              i_REQ;
  logic [2*N_REQ-1:0]            i_REQ_MODE;
  logic [G*N_REQ-1:0]            i_REQ_PIXEL;
  logic [N_COLOR_BITS*N_REQ-1:0] i_REQ_TEXT_COLOR;
  logic [N_COLOR_BITS*N_REQ-1:0] i_REQ_BG_COLOR;
  logic [N_REQ-1:0]              o_GNT;
  logic [N_REQ-1:0]              o_DONE;
  logic                          o_ERR;
  logic                          o_INIT_DONE;
  logic [1:0]                    o_MODE;
  logic                          o_START;
  logic [G-1:0]                  o_PIXEL;
  logic [N_COLOR_BITS-1:0]       o_TEXT_COLOR;
  logic [N_COLOR_BITS-1:0]       o_BACKGROUND_COLOR;
  logic                          i_READY;
  logic [2:0]                    state_dbg;

  modport slave (
    input  i_REQ, i_REQ_MODE, i_REQ_PIXEL, i_REQ_TEXT_COLOR, i_REQ_BG_COLOR, i_READY,
    output o_GNT, o_DONE, o_ERR, o_INIT_DONE, o_MODE, o_START, o_PIXEL,
           o_TEXT_COLOR, o_BACKGROUND_COLOR, state_dbg
  );

  modport master (
    output i_REQ, i_REQ_MODE, i_REQ_PIXEL, i_REQ_TEXT_COLOR, i_REQ_BG_COLOR, i_READY,
    input  o_GNT, o_DONE, o_ERR, o_INIT_DONE, o_MODE, o_START, o_PIXEL,
           o_TEXT_COLOR, o_BACKGROUND_COLOR, state_dbg
  );
endinterface

// File: rtl/oled_request_scheduler.sv
// Round-robin arbiter sharing one OLED display engine among N_REQ requesters,
// issuing the power-on sequence first and latching the winner's payload.
module oled_request_scheduler #(
  parameter int N_REQ          = 4,
  parameter int ASCII_COL_SIZE = 8,
  parameter int ASCII_ROW_SIZE = 8,
  parameter int N_COLOR_BITS   = 8,
  parameter int ACK_TIMEOUT    = 1024
) (
  input logic                    i_CLK,
  input logic                    i_RST,
  oled_request_scheduler_if.slave bus
);
  localparam int G   = ASCII_COL_SIZE * ASCII_ROW_SIZE;
  localparam int IW  = $clog2(N_REQ);
  localparam int IW1 = IW + 1;
  localparam int CW  = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_ACK       = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                  state;
  logic                    init_flag;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [N_REQ-1:0]        gnt_q;
  logic [N_REQ-1:0]        done_q;
  logic                    err_q;
  logic                    init_done_q;
  logic                    start_q;
  logic [1:0]              mode_q;
  logic [G-1:0]            pixel_q;
  logic [N_COLOR_BITS-1:0] text_q;
  logic [N_COLOR_BITS-1:0] bg_q;

  logic [1:0]              mode_arr [N_REQ];
  logic [G-1:0]            pixel_arr[N_REQ];
  logic [N_COLOR_BITS-1:0] text_arr [N_REQ];
  logic [N_COLOR_BITS-1:0] bg_arr   [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign mode_arr[k]  = bus.i_REQ_MODE[2*k +: 2];
    assign pixel_arr[k] = bus.i_REQ_PIXEL[G*k +: G];
    assign text_arr[k]  = bus.i_REQ_TEXT_COLOR[N_COLOR_BITS*k +: N_COLOR_BITS];
    assign bg_arr[k]    = bus.i_REQ_BG_COLOR[N_COLOR_BITS*k +: N_COLOR_BITS];
  end

  // First requesting index at or after ptr, wrapping modulo N_REQ.
  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic [IW1-1:0] sum;
  logic [IW-1:0] cand;
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + IW1'(i);
      if (sum >= IW1'(N_REQ)) sum = sum - IW1'(N_REQ);
      cand = sum[IW-1:0];
      if (!sel_valid && bus.i_REQ[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  logic [IW-1:0] idx_next;
  assign idx_next = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state       <= S_INIT_WAIT;
      init_flag   <= 1'b1;
      ptr         <= '0;
      idx         <= '0;
      cnt         <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      start_q     <= 1'b0;
      mode_q      <= 2'b00;
      pixel_q     <= '0;
      text_q      <= '0;
      bg_q        <= '0;
    end else begin
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (bus.i_READY) begin
            mode_q  <= 2'b00;
            pixel_q <= '0;
            text_q  <= '0;
            bg_q    <= '0;
            start_q <= 1'b1;
            state   <= S_START;
          end
        end
        S_IDLE: begin
          if (sel_valid) begin
            mode_q         <= mode_arr[sel_idx];
            pixel_q        <= pixel_arr[sel_idx];
            text_q         <= text_arr[sel_idx];
            bg_q           <= bg_arr[sel_idx];
            idx            <= sel_idx;
            gnt_q[sel_idx] <= 1'b1;
            start_q        <= 1'b1;
            state          <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_ACK;
        end
        S_ACK: begin
          if (!bus.i_READY) begin
            state <= S_RUN;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            // Engine never acknowledged: report and retry init or move on.
            err_q <= 1'b1;
            if (init_flag) begin
              state <= S_INIT_WAIT;
            end else begin
              done_q[idx] <= 1'b1;
              ptr         <= idx_next;
              state       <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (bus.i_READY) begin
            if (init_flag) begin
              init_flag   <= 1'b0;
              init_done_q <= 1'b1;
            end else begin
              done_q[idx] <= 1'b1;
              ptr         <= idx_next;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT_WAIT;
      endcase
    end
  end

  assign bus.o_GNT              = gnt_q;
  assign bus.o_DONE             = done_q;
  assign bus.o_ERR              = err_q;
  assign bus.o_INIT_DONE        = init_done_q;
  assign bus.o_MODE             = mode_q;
  assign bus.o_START            = start_q;
  assign bus.o_PIXEL            = pixel_q;
  assign bus.o_TEXT_COLOR       = text_q;
  assign bus.o_BACKGROUND_COLOR = bg_q;
  assign bus.state_dbg          = state;
endmodule

// File: tb/tb_oled_request_scheduler.sv
// Randomized bench for oled_request_scheduler with a round-robin reference
// model and a small display-engine handshake driver.
module tb_oled_request_scheduler;
  localparam int N  = 4;
  localparam int G  = 64;
  localparam int CB = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_request_scheduler_if #(.N_REQ(N), .G(G), .N_COLOR_BITS(CB)) bus ();

  oled_request_scheduler #(
    .N_REQ(N), .ASCII_COL_SIZE(8), .ASCII_ROW_SIZE(8),
    .N_COLOR_BITS(CB), .ACK_TIMEOUT(TO)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst_n),
    .bus(bus)
  );

  int vec_count = 0;
  int err_count = 0;
  int model_ptr = 0;
  logic [N-1:0] exp_q[$];

  logic [1:0]    mode_v[N];
  logic [G-1:0]  pix_v[N];
  logic [CB-1:0] txt_v[N];
  logic [CB-1:0] bg_v[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_payload();
    for (int k = 0; k < N; k++) begin
      bus.i_REQ_MODE[2*k +: 2]          = mode_v[k];
      bus.i_REQ_PIXEL[G*k +: G]         = pix_v[k];
      bus.i_REQ_TEXT_COLOR[CB*k +: CB]  = txt_v[k];
      bus.i_REQ_BG_COLOR[CB*k +: CB]    = bg_v[k];
    end
  endtask

  task automatic randomize_payload();
    for (int k = 0; k < N; k++) begin
      mode_v[k] = 2'($urandom_range(0, 3));
      pix_v[k]  = {$urandom, $urandom};
      txt_v[k]  = 8'($urandom_range(0, 255));
      bg_v[k]   = 8'($urandom_range(0, 255));
    end
    apply_payload();
  endtask

  // Reference arbiter: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic wait_start(output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cycles++;
      if (bus.o_START) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Engine acknowledges on the first ACK sample, stays busy, then completes.
  task automatic engine(input int low);
    bus.i_READY = 1'b0;
    repeat (low) tick();
    bus.i_READY = 1'b1;
    tick();
  endtask

  task automatic run_op(input logic [N-1:0] req, input int low, input bit drop);
    int e;
    int cyc;
    bit seen;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] got_exp;
    logic [1:0] em;
    logic [G-1:0] ep;
    logic [CB-1:0] et, eb;
    bus.i_REQ = req;
    e = rr_pick(req, model_ptr);
    exp_gnt = '0;
    exp_gnt[e] = 1'b1;
    em = mode_v[e]; ep = pix_v[e]; et = txt_v[e]; eb = bg_v[e];
    exp_q.push_back(exp_gnt);
    wait_start(seen, cyc);
    vec_count++;
    if (!seen) begin
      err_count++;
      $display("FAIL op_start: no o_START within bound, expected grant %b", exp_gnt);
      void'(exp_q.pop_front());
      return;
    end
    got_exp = exp_q.pop_front();
    vec_count++;
    if (bus.o_GNT !== got_exp) begin
      err_count++; $display("FAIL op_gnt: got %b expected %b", bus.o_GNT, got_exp);
    end
    vec_count++;
    if (bus.o_MODE !== em) begin
      err_count++; $display("FAIL op_mode: got %b expected %b", bus.o_MODE, em);
    end
    vec_count++;
    if (bus.o_PIXEL !== ep) begin
      err_count++; $display("FAIL op_pixel: got %h expected %h", bus.o_PIXEL, ep);
    end
    vec_count++;
    if (bus.o_TEXT_COLOR !== et || bus.o_BACKGROUND_COLOR !== eb) begin
      err_count++;
      $display("FAIL op_colors: got %h/%h expected %h/%h",
               bus.o_TEXT_COLOR, bus.o_BACKGROUND_COLOR, et, eb);
    end
    if (drop) bus.i_REQ = '0;
    randomize_payload();
    engine(low);
    vec_count++;
    if (bus.o_DONE !== exp_gnt) begin
      err_count++; $display("FAIL op_done: got %b expected %b", bus.o_DONE, exp_gnt);
    end
    vec_count++;
    if (bus.o_MODE !== em || bus.o_PIXEL !== ep) begin
      err_count++;
      $display("FAIL op_hold: got %b/%h expected %b/%h", bus.o_MODE, bus.o_PIXEL, em, ep);
    end
    model_ptr = (e + 1) % N;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_READY = 1'b1;
    bus.i_REQ = 4'b1111;
    randomize_payload();
    repeat (3) tick();
    vec_count++;
    if (bus.o_GNT !== '0 || bus.o_DONE !== '0) begin
      err_count++; $display("FAIL reset_gnt_done: got %b/%b expected 0/0", bus.o_GNT, bus.o_DONE);
    end
    vec_count++;
    if (bus.o_ERR !== 1'b0 || bus.o_INIT_DONE !== 1'b0 || bus.o_START !== 1'b0) begin
      err_count++;
      $display("FAIL reset_flags: got err=%b init=%b start=%b expected 0",
               bus.o_ERR, bus.o_INIT_DONE, bus.o_START);
    end
    vec_count++;
    if (bus.o_MODE !== 2'b00 || bus.o_PIXEL !== '0) begin
      err_count++; $display("FAIL reset_payload: got %b/%h expected 0", bus.o_MODE, bus.o_PIXEL);
    end
    vec_count++;
    if (bus.o_TEXT_COLOR !== '0 || bus.o_BACKGROUND_COLOR !== '0) begin
      err_count++;
      $display("FAIL reset_colors: got %h/%h expected 0", bus.o_TEXT_COLOR, bus.o_BACKGROUND_COLOR);
    end
  endtask

  task automatic test_init();
    bit seen;
    int cyc;
    bus.i_REQ = '0;
    rst_n = 1'b1;
    wait_start(seen, cyc);
    vec_count++;
    if (!seen || cyc > 2) begin
      err_count++; $display("FAIL init_start: seen=%b after %0d cycles, expected within 2", seen, cyc);
    end
    vec_count++;
    if (bus.o_MODE !== 2'b00 || bus.o_GNT !== '0 || bus.o_PIXEL !== '0) begin
      err_count++;
      $display("FAIL init_payload: got mode=%b gnt=%b pix=%h expected 0", bus.o_MODE, bus.o_GNT, bus.o_PIXEL);
    end
    vec_count++;
    if (bus.o_INIT_DONE !== 1'b0) begin
      err_count++; $display("FAIL init_early: got %b expected 0", bus.o_INIT_DONE);
    end
    engine(3);
    vec_count++;
    if (bus.o_INIT_DONE !== 1'b1) begin
      err_count++; $display("FAIL init_done: got %b expected 1", bus.o_INIT_DONE);
    end
    vec_count++;
    if (bus.o_DONE !== '0 || bus.o_GNT !== '0) begin
      err_count++; $display("FAIL init_no_done: got %b/%b expected 0/0", bus.o_DONE, bus.o_GNT);
    end
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++) run_op(4'b1111, $urandom_range(2, 4), 1'b0);
  endtask

  task automatic test_single();
    mode_v[2] = 2'b01;
    pix_v[2]  = {8'h0C, 8'h1E, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h00};
    txt_v[2]  = 8'hFF;
    bg_v[2]   = 8'hA5;
    apply_payload();
    run_op(4'b0100, 3, 1'b1);
  endtask

  task automatic test_wrap();
    run_op(4'b1000, 2, 1'b1);
    run_op(4'b1001, 2, 1'b0);
    run_op(4'b1001, 3, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_op(4'($urandom_range(1, 15)), $urandom_range(2, 5), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_timeout();
    int a, b, cyc, n;
    bit seen;
    logic [N-1:0] ea;
    a = $urandom_range(0, N - 1);
    b = (a + 1 + $urandom_range(0, 2)) % N;
    ea = '0; ea[a] = 1'b1;
    bus.i_REQ = ea;
    bus.i_READY = 1'b1;
    wait_start(seen, cyc);
    vec_count++;
    if (!seen || bus.o_GNT !== ea) begin
      err_count++; $display("FAIL to_gnt: seen=%b got %b expected %b", seen, bus.o_GNT, ea);
    end
    bus.i_REQ = '0;
    bus.i_REQ[b] = 1'b1;
    n = 0;
    for (int c = 0; c < TO + 10; c++) begin
      tick();
      n++;
      if (bus.o_ERR) break;
    end
    vec_count++;
    if (bus.o_ERR !== 1'b1 || n != TO + 1) begin
      err_count++; $display("FAIL to_err: err=%b after %0d cycles, expected 1 after %0d", bus.o_ERR, n, TO + 1);
    end
    vec_count++;
    if (bus.o_DONE !== ea) begin
      err_count++; $display("FAIL to_done: got %b expected %b", bus.o_DONE, ea);
    end
    model_ptr = (a + 1) % N;
    run_op(bus.i_REQ, 3, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    int cyc;
    mode_v[1] = 2'b11;
    pix_v[1]  = 64'hFFFF_0000_FFFF_0000;
    apply_payload();
    bus.i_REQ = 4'b0010;
    wait_start(seen, cyc);
    bus.i_READY = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vec_count++;
    if (bus.o_MODE !== 2'b00 || bus.o_PIXEL !== '0 || bus.o_START !== 1'b0) begin
      err_count++;
      $display("FAIL rst_run_payload: got mode=%b pix=%h start=%b expected 0", bus.o_MODE, bus.o_PIXEL, bus.o_START);
    end
    vec_count++;
    if (bus.o_INIT_DONE !== 1'b0 || bus.o_GNT !== '0 || bus.o_DONE !== '0) begin
      err_count++;
      $display("FAIL rst_run_flags: got init=%b gnt=%b done=%b expected 0", bus.o_INIT_DONE, bus.o_GNT, bus.o_DONE);
    end
    bus.i_REQ = 4'b1111;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vec_count++;
      if (bus.o_INIT_DONE !== 1'b0 || bus.o_START !== 1'b0 || bus.o_GNT !== '0) begin
        err_count++;
        $display("FAIL rst_reinit_wait: got init=%b start=%b gnt=%b expected 0",
                 bus.o_INIT_DONE, bus.o_START, bus.o_GNT);
      end
    end
    bus.i_READY = 1'b1;
    wait_start(seen, cyc);
    vec_count++;
    if (!seen || bus.o_MODE !== 2'b00 || bus.o_GNT !== '0) begin
      err_count++; $display("FAIL rst_reinit_start: seen=%b mode=%b gnt=%b expected 1/00/0", seen, bus.o_MODE, bus.o_GNT);
    end
    engine(2);
    vec_count++;
    if (bus.o_INIT_DONE !== 1'b1) begin
      err_count++; $display("FAIL rst_reinit_done: got %b expected 1", bus.o_INIT_DONE);
    end
    model_ptr = 0;
    run_op(4'b1111, 2, 1'b1);
  endtask

  initial begin
    bus.i_REQ = '0;
    bus.i_REQ_MODE = '0;
    bus.i_REQ_PIXEL = '0;
    bus.i_REQ_TEXT_COLOR = '0;
    bus.i_REQ_BG_COLOR = '0;
    bus.i_READY = 1'b1;
    test_reset();
    test_init();
    test_round_robin();
    test_single();
    test_wrap();
    test_random();
    test_timeout();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule

// File: doc/oled_request_scheduler.md
# oled_request_scheduler

Round-robin scheduler that shares one OLED_interface instance among N_REQ requesters (button logic, text writer, test pattern source, etc.). After reset it automatically issues the power-on sequence (mode 2'b00), then grants one requester at a time, latches its mode, glyph and colors, pulses the start strobe and holds the grant until the display engine reports ready again. It sits between the board-level request sources and OLED_interface.

## Interface
- N_REQ, 4: number of requesters (2..8)
- ASCII_COL_SIZE, 8: glyph width in pixels
- ASCII_ROW_SIZE, 8: glyph height in pixels
- N_COLOR_BITS, 8: color word width
- ACK_TIMEOUT, 1024: max cycles from o_START until i_READY must fall

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  asynchronous, active-low reset (0 = reset)
- i_REQ  in  N_REQ  per-requester request level
- i_REQ_MODE  in  2*N_REQ  mode per requester, requester k at [2k+1:2k]
- i_REQ_PIXEL  in  G*N_REQ  glyph per requester, G = ASCII_COL_SIZE*ASCII_ROW_SIZE, slice k at [G*k+G-1:G*k]
- i_REQ_TEXT_COLOR  in  N_COLOR_BITS*N_REQ  text color per requester
- i_REQ_BG_COLOR  in  N_COLOR_BITS*N_REQ  background color per requester
- o_GNT  out  N_REQ  one-hot, one-cycle pulse: payload of requester k latched
- o_DONE  out  N_REQ  one-hot, one-cycle pulse: requester k's operation finished
- o_ERR  out  1  one-cycle pulse: ACK timeout
- o_INIT_DONE  out  1  level, power-on sequence completed
- o_MODE  out  2  to OLED_interface i_MODE
- o_START  out  1  to OLED_interface i_START, one-cycle pulse
- o_PIXEL  out  G  to OLED_interface i_PIXEL
- o_TEXT_COLOR  out  N_COLOR_BITS  to i_TEXT_COLOR
- o_BACKGROUND_COLOR  out  N_COLOR_BITS  to i_BACKGROUND_COLOR
- i_READY  in  1  from OLED_interface o_READY

## Operation
- States: S_INIT_WAIT, S_IDLE, S_START, S_ACK, S_RUN.
- Reset: state S_INIT_WAIT, init flag set, RR pointer 0, all outputs 0 (o_MODE 2'b00, payload regs 0).
- S_INIT_WAIT: when i_READY=1, load o_MODE=2'b00, colors/pixel 0, go S_START. No o_GNT in init.
- S_IDLE: if any i_REQ, pick first set bit at or after pointer (wrapping modulo N_REQ); latch its mode/pixel/colors into output regs, record index, go S_START. o_GNT[idx]=1 in S_START cycle. No request: stay.
- S_START: o_START=1 for exactly this cycle; clear timeout counter; go S_ACK.
- S_ACK: wait i_READY=0 -> S_RUN. Counter increments each cycle; reaching ACK_TIMEOUT-1 with i_READY still 1: pulse o_ERR, pulse o_DONE[idx] (none if init), return to S_IDLE (init: S_INIT_WAIT, retry).
- S_RUN: wait i_READY=1; then pulse o_DONE[idx] (or set o_INIT_DONE if init), pointer = idx+1 mod N_REQ, go S_IDLE.
- Payload outputs hold latched values from latch until next latch; requesters may change or drop inputs after o_GNT.
- Requests dropped before grant are simply not served; no queueing beyond the level inputs.
- Requests in S_INIT_WAIT..S_RUN are ignored (not lost; sampled in next S_IDLE).
- o_INIT_DONE stays 1 until reset.

## Timing
- Request seen at edge k in S_IDLE -> o_GNT and o_START high during cycle k+1 -> S_ACK from k+2.
- Minimum turnaround IDLE to IDLE: 4 cycles (START, ACK with READY already 0 on first sample, RUN with READY 1).
- o_DONE and o_ERR asserted in the cycle after the edge that leaves S_RUN/S_ACK; registered outputs only, no combinational path from i_REQ or i_READY to any output.
- Asynchronous reset mid-operation: all outputs to reset values immediately, including o_START; init sequence repeats.
- Fairness: a continuously-requesting requester waits at most N_REQ-1 operations.

## Test plan
- Reset, i_READY=1: one o_START with o_MODE=00 ~2 cycles after release; drop READY 3 cycles, raise -> o_INIT_DONE=1, no o_GNT/o_DONE.
- After init, i_REQ=4'b0100, mode 01, pixel {8'h0C,8'h1E,8'h33,8'h33,8'h3F,8'h33,8'h33,8'h00}, bg 8'hA5 -> o_GNT=4'b0100 with o_START, outputs carry exact payload, o_DONE=4'b0100 after READY returns.
- i_REQ=4'b1111 held, model READY handshake -> grant order 0,1,2,3,0 (pointer 0 after init).
- Pointer wrap: last grant 3, i_REQ=4'b1001 -> next grant 0, then 3.
- i_READY stuck 1 after o_START -> o_ERR and o_DONE[idx] pulse exactly ACK_TIMEOUT cycles after S_ACK entry; scheduler returns to S_IDLE and serves next request.
- Assert i_RST=0 during S_RUN -> outputs 0 same cycle; after release init repeats and o_INIT_DONE=0 until done.
